sun_pll_lock_det: RTL and testbench

- Digital lock detector at the consumer end of the PLL output clock.
- Runs on the PLL output clock CK and samples reference clock CK_REF as data through a 2-flop synchronizer.
- Measures CK cycles per reference period and compares against the feedback divide ratio.
- Asserts LOCK after repeated in-tolerance periods; flags a lost reference so supervisory logic can re-kick or power-cycle the loop.

---
 rtl/sun_pll_lock_det.sv | 160 ++++++++++++++++
 tb/tb_sun_pll_lock_det.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sun_pll_lock_det.sv
// PLL lock detector: counts CK cycles per CK_REF period and checks each count against DIV +/- TOL.
// Latency: CK_REF rise to CNT_VLD is 3 CK cycles; LOCK is 1 cycle behind STATE. No backpressure; CNT_VLD is a pulse.
module sun_pll_lock_det #(
   parameter int DIV        = 32,
   parameter int TOL        = 2,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int CW         = 8
) (
   input  logic          CK,
   input  logic          RST,
   input  logic          EN,
   input  logic          CK_REF,
   output logic          LOCK,
   output logic [CW-1:0] CNT,
   output logic          CNT_VLD,
   output logic          REF_LOST,
   output logic [1:0]    STATE
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARM    = 2'd1;
   localparam logic [1:0] S_ACQ    = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_CNT + 1);
   localparam int LO = (DIV > TOL) ? DIV - TOL : 0;
   localparam int HI = DIV + TOL;

   localparam logic [CW-1:0] CYC_MAX  = '1;
   localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
   localparam logic [UW-1:0] BAD_TGT  = UW'(UNLOCK_CNT);

   logic          sync1, sync2, sync3;
   logic          ref_edge;
   logic [CW-1:0] cyc;
   logic [CW-1:0] capture;
   logic          meas_good;
   logic [GW-1:0] good_cnt, good_inc;
   logic [UW-1:0] bad_cnt, bad_inc;
   logic [1:0]    state;
   logic          lock_q;
   logic [CW-1:0] cnt_q;
   logic          cnt_vld_q;
   logic          ref_lost_q;

   // CK_REF is asynchronous; two flops resolve metastability, the third gives the rising-edge reference.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= CK_REF;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign ref_edge  = sync2 & ~sync3;
   assign capture   = (cyc == CYC_MAX) ? cyc : cyc + CW'(1);
   assign meas_good = (capture != CYC_MAX) && (int'(capture) >= LO) && (int'(capture) <= HI);
   assign good_inc  = good_cnt + GW'(1);
   assign bad_inc   = bad_cnt + UW'(1);

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         cyc        <= '0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         lock_q     <= 1'b0;
         cnt_q      <= '0;
         cnt_vld_q  <= 1'b0;
         ref_lost_q <= 1'b0;
      end else begin
         cnt_vld_q <= 1'b0;
         lock_q    <= (state == S_LOCKED);
         if (!EN) begin
            state      <= S_IDLE;
            cyc        <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            ref_lost_q <= 1'b0;
            lock_q     <= 1'b0;
         end else begin
            if (state == S_IDLE || ref_edge) begin
               cyc <= '0;
            end else begin
               cyc <= capture;
            end

            // An edge landing on the saturated count wins over the loss flag.
            if (state != S_IDLE) begin
               if (ref_edge) begin
                  ref_lost_q <= 1'b0;
               end else if (cyc == CYC_MAX) begin
                  ref_lost_q <= 1'b1;
               end
            end

            case (state)
               S_IDLE: begin
                  state    <= S_ARM;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
               end
               S_ARM: begin
                  if (ref_edge) begin
                     state    <= S_ACQ;
                     good_cnt <= '0;
                     bad_cnt  <= '0;
                  end
               end
               S_ACQ, S_LOCKED: begin
                  if (ref_lost_q) begin
                     state    <= S_ARM;
                     good_cnt <= '0;
                     bad_cnt  <= '0;
                     lock_q   <= 1'b0;
                  end else if (ref_edge) begin
                     cnt_q     <= capture;
                     cnt_vld_q <= 1'b1;
                     if (state == S_ACQ) begin
                        if (meas_good) begin
                           good_cnt <= good_inc;
                           if (good_inc == GOOD_TGT) begin
                              state   <= S_LOCKED;
                              bad_cnt <= '0;
                           end
                        end else begin
                           good_cnt <= '0;
                        end
                     end else begin
                        if (meas_good) begin
                           bad_cnt <= '0;
                        end else begin
                           bad_cnt <= bad_inc;
                           if (bad_inc == BAD_TGT) begin
                              state    <= S_ACQ;
                              good_cnt <= '0;
                           end
                        end
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign LOCK     = lock_q;
   assign CNT      = cnt_q;
   assign CNT_VLD  = cnt_vld_q;
   assign REF_LOST = ref_lost_q;
   assign STATE    = state;

endmodule

// File: tb/tb_sun_pll_lock_det.sv
// Bench for sun_pll_lock_det: directed and random CK_REF periods checked against a per-edge model.
module tb_sun_pll_lock_det;

   localparam int DIV        = 32;
   localparam int TOL        = 2;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 2;
   localparam int CW         = 8;
   localparam int SAT        = (1 << CW) - 1;

   logic          CK     = 1'b0;
   logic          RST    = 1'b1;
   logic          EN     = 1'b0;
   logic          CK_REF = 1'b0;
   logic          LOCK;
   logic [CW-1:0] CNT;
   logic          CNT_VLD;
   logic          REF_LOST;
   logic [1:0]    STATE;

   sun_pll_lock_det #(
      .DIV(DIV), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CW(CW)
   ) dut (
      .CK(CK), .RST(RST), .EN(EN), .CK_REF(CK_REF),
      .LOCK(LOCK), .CNT(CNT), .CNT_VLD(CNT_VLD), .REF_LOST(REF_LOST), .STATE(STATE)
   );

   always #5 CK = ~CK;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model: outcome of each reference edge, tracked as streak lengths.
   bit m_armed;
   bit m_locked;
   int m_good;
   int m_bad;
   int m_gap;
   int m_cnt;

   int   vld_n;
   int   cnt_obs;
   logic lock_at_vld;
   logic lock_after;
   bit   lost_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_state();
      return m_armed ? 1 : (m_locked ? 3 : 2);
   endfunction

   // One reference period of p cycles, starting with a rising edge.
   task automatic run_period(input int p);
      int vld_at;
      vld_n     = 0;
      vld_at    = -1;
      lost_seen = 0;
      for (int j = 0; j < p; j++) begin
         @(negedge CK);
         CK_REF = (j < p / 2);
         if (j >= 3 && REF_LOST) lost_seen = 1;
         if (CNT_VLD) begin
            vld_n++;
            vld_at      = j;
            cnt_obs     = CNT;
            lock_at_vld = LOCK;
         end
         if (vld_at >= 0 && j == vld_at + 1) lock_after = LOCK;
      end
   endtask

   task automatic step(input int p);
      bit meas;
      bit was_locked;
      bit good;
      int capture;
      capture    = (m_gap > SAT) ? SAT : m_gap;
      meas       = !m_armed;
      was_locked = m_locked;
      if (m_armed) begin
         m_armed = 0;
         m_good  = 0;
         m_bad   = 0;
      end else begin
         good  = (capture != SAT) && (capture >= DIV - TOL) && (capture <= DIV + TOL);
         m_cnt = capture;
         if (m_locked) begin
            m_bad = good ? 0 : m_bad + 1;
            if (m_bad >= UNLOCK_CNT) begin
               m_locked = 0;
               m_good   = 0;
            end
         end else begin
            m_good = good ? m_good + 1 : 0;
            if (m_good >= LOCK_CNT) begin
               m_locked = 1;
               m_bad    = 0;
            end
         end
      end
      m_gap = p;
      run_period(p);
      check("vld_count", 32'(vld_n), 32'(meas));
      if (meas) check("cnt_capture", 32'(cnt_obs), 32'(capture));
      check("cnt_end", 32'(CNT), 32'(m_cnt));
      check("lock", 32'(LOCK), 32'(m_locked));
      check("state", 32'(STATE), 32'(exp_state()));
      check("ref_lost", 32'(lost_seen | REF_LOST), 32'd0);
      if (meas && was_locked != m_locked) begin
         check("lock_at_vld", 32'(lock_at_vld), 32'(was_locked));
         check("lock_after_vld", 32'(lock_after), 32'(m_locked));
      end
   endtask

   task automatic en_abort(input string tag);
      @(negedge CK);
      EN = 1'b0;
      @(negedge CK);
      check({tag, "_state"}, 32'(STATE), 32'd0);
      check({tag, "_cnt_hold"}, 32'(CNT), 32'(m_cnt));
      check({tag, "_lock"}, 32'(LOCK), 32'd0);
      check({tag, "_vld"}, 32'(CNT_VLD), 32'd0);
      EN       = 1'b1;
      m_armed  = 1;
      m_locked = 0;
      m_good   = 0;
      m_bad    = 0;
   endtask

   initial begin
      int first_lost;
      int first_arm;
      int rel;
      int p;
      logic lock_at_arm;

      m_armed  = 1;
      m_locked = 0;
      m_good   = 0;
      m_bad    = 0;
      m_gap    = SAT + 1;
      m_cnt    = 0;

      // Reset held with EN high and CK_REF toggling.
      EN = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge CK);
         CK_REF = ((i % 4) < 2);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge CK);
         CK_REF = 1'b0;
      end
      check("rst_lock", 32'(LOCK), 32'd0);
      check("rst_cnt", 32'(CNT), 32'd0);
      check("rst_vld", 32'(CNT_VLD), 32'd0);
      check("rst_ref_lost", 32'(REF_LOST), 32'd0);
      check("rst_state", 32'(STATE), 32'd0);
      RST = 1'b0;
      @(negedge CK);
      check("post_rst_state", 32'(STATE), 32'd1);

      // Acquisition at the nominal ratio.
      for (int i = 0; i < 5; i++) step(DIV);

      en_abort("abort_locked");

      // Tolerance edges: 29 breaks the streak, then four 34s lock.
      step(30); step(34); step(30); step(29);
      step(34); step(34); step(34); step(34); step(32);

      // Unlock hysteresis and relock.
      step(40); step(32); step(28); step(36);
      for (int i = 0; i < 5; i++) step(32);

      // A gap of 256 meets saturation on the edge: bad measurement, no loss flag.
      step(256); step(32); step(32);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    p = int'($urandom_range(DIV + TOL, DIV - TOL));
            2:       p = ($urandom_range(0, 1) == 1) ? DIV - TOL - 1 : DIV + TOL + 1;
            default: p = int'($urandom_range(120, 8));
         endcase
         step(p);
      end
      for (int i = 0; i < 5; i++) step(32);

      // Reference loss: the edge pulse is seen 3 samples after the rise, the count saturates 2^CW-1 later.
      first_lost  = -1;
      first_arm   = -1;
      lock_at_arm = 1'bx;
      for (int j = 0; j < 300; j++) begin
         @(negedge CK);
         CK_REF = 1'b0;
         rel    = m_gap + j;
         if (first_lost < 0 && REF_LOST) first_lost = rel;
         if (first_arm < 0 && STATE == 2'd1) begin
            first_arm   = rel;
            lock_at_arm = LOCK;
         end
      end
      check("lost_time", 32'(first_lost), 32'(3 + (1 << CW)));
      check("lost_arm_time", 32'(first_arm), 32'(4 + (1 << CW)));
      check("lost_lock", 32'(lock_at_arm), 32'd0);
      check("lost_held", 32'(REF_LOST), 32'd1);
      check("lost_state", 32'(STATE), 32'd1);
      m_armed  = 1;
      m_locked = 0;
      m_gap    = m_gap + 300;
      for (int i = 0; i < 5; i++) step(32);

      // Abort from ACQ, then relock.
      step(32); step(32); step(32);
      en_abort("abort_acq");
      for (int i = 0; i < 5; i++) step(32);

      // Asynchronous reset between clock edges.
      @(negedge CK);
      #2;
      RST = 1'b1;
      #1;
      check("arst_lock", 32'(LOCK), 32'd0);
      check("arst_state", 32'(STATE), 32'd0);
      check("arst_cnt", 32'(CNT), 32'd0);
      check("arst_ref_lost", 32'(REF_LOST), 32'd0);
      @(negedge CK);
      RST = 1'b0;
      @(negedge CK);
      check("arst_resume_state", 32'(STATE), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
